// File: rtl/dump_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dump_sequencer_if
//  Description : Bus bundle between the dump sequencer and its surroundings.
//                Carries the dump request/status, the register-bank and
//                data-memory read ports and the UART TX byte handshake.
//                master : the sequencer (drives o_*, samples i_*)
//                slave  : debug unit / memories / UART (drives i_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dump_sequencer_if #(
  parameter int IM_ADDR_LENGTH = 32,
  parameter int DM_ADDR_LENGTH = 32,
  parameter int RBITS          = 5,
  parameter int WORD_WIDTH     = 32
);
  logic                      i_start;
  logic [IM_ADDR_LENGTH-1:0] i_pc;
  logic [RBITS-1:0]          o_rb_addr;
  logic [WORD_WIDTH-1:0]     i_rb_data;
  logic [DM_ADDR_LENGTH-1:0] o_dm_addr;
  logic [WORD_WIDTH-1:0]     i_dm_data;
  logic [7:0]                o_tx_data;
  logic                      o_tx_start;
  logic                      i_tx_done;
  logic                      o_owner;
  logic                      o_busy;
  logic                      o_done;

  modport master (
    input  i_start, i_pc, i_rb_data, i_dm_data, i_tx_done,
    output o_rb_addr, o_dm_addr, o_tx_data, o_tx_start, o_owner, o_busy, o_done
  );

  modport slave (
    output i_start, i_pc, i_rb_data, i_dm_data, i_tx_done,
    input  o_rb_addr, o_dm_addr, o_tx_data, o_tx_start, o_owner, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dump_sequencer
//  Description : After a halt, takes over register-bank read port 2 and the
//                data-memory address, then walks PC, BANK_SIZE registers and
//                DM_DUMP_WORDS data-memory words, sending every 32-bit word
//                MSB first to the UART one byte per start/done handshake.
//  Ports       : clk, rst (sync, active high)
//                bus.master : i_start, i_pc, o_rb_addr/i_rb_data,
//                             o_dm_addr/i_dm_data, o_tx_data/o_tx_start/
//                             i_tx_done, o_owner, o_busy, o_done
//  Revision    : 1.0 - initial release
// ============================================================================
module dump_sequencer #(
  parameter int                        IM_ADDR_LENGTH = 32,
  parameter int                        DM_ADDR_LENGTH = 32,
  parameter int                        RBITS          = 5,
  parameter int                        BANK_SIZE      = 32,
  parameter logic [DM_ADDR_LENGTH-1:0] DM_BASE        = '0,
  parameter int                        DM_DUMP_WORDS  = 32,
  parameter int                        WORD_WIDTH     = 32
) (
  input wire               clk,
  input wire               rst,
  dump_sequencer_if.master bus
);

  // Item 0 is the PC, then registers, then data-memory words.
  localparam int C_LAST_ITEM = BANK_SIZE + DM_DUMP_WORDS;
  localparam int C_ITEM_W    = $clog2(C_LAST_ITEM + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [C_ITEM_W-1:0]   item_q,  item_d;
  logic [1:0]            byte_q,  byte_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;

  logic [31:0]           w_item;
  logic [31:0]           w_dm_k;
  logic                  w_in_rb;
  logic                  w_in_dm;
  logic                  w_owner;
  logic [WORD_WIDTH-1:0] w_word;

  // Section decode is purely a function of the item counter, so the
  // addresses stay put from LOAD until NEXT advances the item.
  assign w_item  = 32'(item_q);
  assign w_in_rb = (w_item >= 32'd1) && (w_item <= 32'(BANK_SIZE));
  assign w_in_dm = (w_item > 32'(BANK_SIZE));
  assign w_dm_k  = w_item - 32'(BANK_SIZE) - 32'd1;
  assign w_owner = (state_q != S_IDLE);

  always_comb begin
    w_word = bus.i_dm_data;
    if (item_q == '0) begin
      w_word = WORD_WIDTH'(bus.i_pc);
    end else if (w_in_rb) begin
      w_word = bus.i_rb_data;
    end
  end

  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          item_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_LATCH;
      S_LATCH: begin
        shift_d = w_word;
        byte_d  = 2'd0;
        state_d = S_SEND;
      end
      S_SEND:  state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        // Only here does a tx_done pulse mean anything.
        if (bus.i_tx_done) begin
          if (byte_q == 2'd3) begin
            state_d = S_NEXT;
          end else begin
            shift_d = {shift_q[WORD_WIDTH-9:0], 8'h00};
            byte_d  = byte_q + 2'd1;
            state_d = S_SEND;
          end
        end
      end
      S_NEXT: begin
        if (item_q == C_ITEM_W'(C_LAST_ITEM)) begin
          state_d = S_DONE;
        end else begin
          item_d  = item_q + C_ITEM_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      item_q  <= '0;
      byte_q  <= 2'd0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
    end
  end

  assign bus.o_rb_addr  = (w_owner && w_in_rb) ? RBITS'(w_item - 32'd1) : '0;
  // 4*k computed at address width so it wraps like the memory bus does.
  assign bus.o_dm_addr  = (w_owner && w_in_dm)
                          ? DM_BASE + (DM_ADDR_LENGTH'(w_dm_k) << 2) : '0;
  assign bus.o_tx_data  = shift_q[WORD_WIDTH-1 -: 8];
  assign bus.o_tx_start = (state_q == S_SEND);
  assign bus.o_owner    = w_owner;
  assign bus.o_busy     = w_owner;
  assign bus.o_done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dump_sequencer
//  Description : Self-checking bench for dump_sequencer. Two instances: the
//                default configuration and a small one (BANK_SIZE=2,
//                DM_DUMP_WORDS=1, DM_BASE=0x100). Byte streams are compared
//                against a word-list model built from PC/register/memory
//                contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dump_sequencer;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  typedef struct {
    logic       start;
    logic       spur;
    logic [2:0] exp_bot;   // {busy, owner, tx_start}
  } lvec_t;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } bvec_t;

  typedef struct {
    logic        is_dm;
    int          idx;
    logic [31:0] val;
  } avec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dump_sequencer_if #(.IM_ADDR_LENGTH(32), .DM_ADDR_LENGTH(32), .RBITS(5),
                      .WORD_WIDTH(32)) a_if ();
  dump_sequencer_if #(.IM_ADDR_LENGTH(32), .DM_ADDR_LENGTH(32), .RBITS(5),
                      .WORD_WIDTH(32)) b_if ();

  dump_sequencer #(.IM_ADDR_LENGTH(32), .DM_ADDR_LENGTH(32), .RBITS(5),
                   .BANK_SIZE(32), .DM_BASE(32'h0), .DM_DUMP_WORDS(32),
                   .WORD_WIDTH(32))
    dut_a (.clk(clk), .rst(rst), .bus(a_if.master));

  dump_sequencer #(.IM_ADDR_LENGTH(32), .DM_ADDR_LENGTH(32), .RBITS(5),
                   .BANK_SIZE(2), .DM_BASE(32'h100), .DM_DUMP_WORDS(1),
                   .WORD_WIDTH(32))
    dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

  // ---------------- environment A (default configuration) ----------------
  logic [31:0] a_reg [32];
  logic [31:0] a_dm  [32];
  logic [31:0] a_pc = 32'h0;
  logic a_start_drv = 1'b0, a_start_mon = 1'b0;
  logic a_spur_drv  = 1'b0, a_spur_mon  = 1'b0, a_uart_done = 1'b0;
  bit   a_lat_rand = 1'b0, a_dist = 1'b0;
  int   a_cd = 0, a_stab_bad = 0, a_ndone = 0, a_last_txd_cyc = 0;
  logic [7:0] a_hold = 8'h0;
  bq_t  a_bytes;
  wq_t  a_rbq, a_dmq;

  assign a_if.i_start   = a_start_drv | a_start_mon;
  assign a_if.i_pc      = a_pc;
  assign a_if.i_rb_data = a_reg[a_if.o_rb_addr];
  assign a_if.i_tx_done = a_uart_done | a_spur_drv | a_spur_mon;
  always @(posedge clk) a_if.i_dm_data <= a_dm[a_if.o_dm_addr[6:2]];

  // UART model plus disturbance injection for instance A.
  always @(negedge clk) begin
    a_uart_done = 1'b0;
    a_spur_mon  = 1'b0;
    a_start_mon = 1'b0;
    if (a_cd > 0) begin
      a_cd--;
      if (a_cd == 0) begin
        a_uart_done    = 1'b1;
        a_last_txd_cyc = cyc;
      end else if (a_if.o_busy && a_if.o_tx_data !== a_hold) begin
        a_stab_bad++;
      end
    end
    if (a_if.o_tx_start) begin
      a_bytes.push_back(a_if.o_tx_data);
      a_rbq.push_back(32'(a_if.o_rb_addr));
      a_dmq.push_back(a_if.o_dm_addr);
      a_hold = a_if.o_tx_data;
      a_cd   = a_lat_rand ? int'($urandom_range(1, 12)) : 10;
      if (a_dist && $urandom_range(0, 2) == 0) a_spur_mon = 1'b1;
    end
    if (a_dist && a_cd == 5) a_start_mon = 1'b1;
    if (a_if.o_done) begin
      a_ndone++;
      if (a_dist) a_start_mon = 1'b1;
    end
  end

  // ---------------- environment B (small configuration) ------------------
  logic [31:0] b_reg [32];
  logic [31:0] b_dm_word = 32'h0;
  logic [31:0] b_pc = 32'h0;
  logic b_start_drv = 1'b0, b_uart_done = 1'b0;
  int   b_cd = 0;
  bq_t  b_bytes;
  wq_t  b_rbq, b_dmq;

  assign b_if.i_start   = b_start_drv;
  assign b_if.i_pc      = b_pc;
  assign b_if.i_rb_data = b_reg[b_if.o_rb_addr];
  assign b_if.i_tx_done = b_uart_done;
  always @(posedge clk)
    b_if.i_dm_data <= (b_if.o_dm_addr == 32'h100) ? b_dm_word : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    b_uart_done = 1'b0;
    if (b_cd > 0) begin
      b_cd--;
      if (b_cd == 0) b_uart_done = 1'b1;
    end
    if (b_if.o_tx_start) begin
      b_bytes.push_back(b_if.o_tx_data);
      b_rbq.push_back(32'(b_if.o_rb_addr));
      b_dmq.push_back(b_if.o_dm_addr);
      b_cd = 3;
    end
  end

  // ---------------- reference model and helpers --------------------------
  function automatic bq_t words_to_bytes(input wq_t w);
    bq_t q;
    foreach (w[i]) begin
      for (int s = 3; s >= 0; s--) q.push_back(w[i][8*s +: 8]);
    end
    return q;
  endfunction

  function automatic wq_t a_words();
    wq_t w;
    w.push_back(a_pc);
    for (int i = 0; i < 32; i++) w.push_back(a_reg[i]);
    for (int k = 0; k < 32; k++) w.push_back(a_dm[k]);
    return w;
  endfunction

  function automatic wq_t b_words();
    wq_t w;
    w.push_back(b_pc);
    w.push_back(b_reg[0]);
    w.push_back(b_reg[1]);
    w.push_back(b_dm_word);
    return w;
  endfunction

  function automatic logic [63:0] wat(input wq_t q, input int i);
    return (i < q.size()) ? 64'(q[i]) : 64'hFFFF_FFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_stream(input string tag, input bq_t got, input bq_t exp);
    int nb = 0;
    int first = -1;
    check({tag, "_byte_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i >= got.size() || got[i] !== exp[i]) begin
        nb++;
        if (first < 0) first = i;
      end
    end
    check($sformatf("%s_bytes_wrong(first@%0d)", tag, first), 64'(nb), 64'd0);
  endtask

  task automatic randomize_a();
    a_pc = $urandom;
    for (int i = 0; i < 32; i++) begin
      a_reg[i] = $urandom;
      a_dm[i]  = $urandom;
    end
  endtask

  task automatic a_clear();
    a_bytes.delete();
    a_rbq.delete();
    a_dmq.delete();
    a_ndone    = 0;
    a_stab_bad = 0;
  endtask

  task automatic a_finish(input string tag);
    bit   ok = 1'b0;
    logic b0, b1;
    int   gap = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (a_if.o_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
    if (ok) begin
      gap = cyc - a_last_txd_cyc;
      b0  = a_if.o_busy;
      @(negedge clk);
      b1  = a_if.o_busy;
      check({tag, "_done_after_last_txdone"}, 64'(gap), 64'd2);
      check({tag, "_busy_fall"}, 64'({b0, b1}), 64'd2);
    end
    repeat (20) @(negedge clk);
    check({tag, "_idle_no_restart"}, 64'({a_if.o_busy, a_if.o_owner}), 64'd0);
    check({tag, "_done_pulses"}, 64'(a_ndone), 64'd1);
    check({tag, "_tx_data_stable"}, 64'(a_stab_bad), 64'd0);
    cmp_stream(tag, a_bytes, words_to_bytes(a_words()));
  endtask

  task automatic b_wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (b_if.o_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  // ---------------- vector tables ----------------------------------------
  lvec_t ltab [7];
  bvec_t btab [12];
  avec_t atab [9];

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected one");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cycle-by-cycle view around the start request; spurious tx_done pulses
    // land in IDLE, LOAD and SEND.
    ltab[0] = '{1'b0, 1'b1, 3'b000};
    ltab[1] = '{1'b1, 1'b1, 3'b000};
    ltab[2] = '{1'b0, 1'b1, 3'b110};
    ltab[3] = '{1'b0, 1'b0, 3'b110};
    ltab[4] = '{1'b0, 1'b1, 3'b111};
    ltab[5] = '{1'b0, 1'b0, 3'b110};
    ltab[6] = '{1'b0, 1'b0, 3'b110};

    btab[0]  = '{0,   8'h00}; btab[1]  = '{1,   8'h00};
    btab[2]  = '{2,   8'h00}; btab[3]  = '{3,   8'h40};
    btab[4]  = '{24,  8'hDE}; btab[5]  = '{25,  8'hAD};
    btab[6]  = '{26,  8'hBE}; btab[7]  = '{27,  8'hEF};
    btab[8]  = '{132, 8'h12}; btab[9]  = '{133, 8'h34};
    btab[10] = '{134, 8'h56}; btab[11] = '{135, 8'h78};

    atab[0] = '{1'b0, 0,   32'd0};   // PC item
    atab[1] = '{1'b0, 4,   32'd0};   // item 1 = r0
    atab[2] = '{1'b0, 24,  32'd5};
    atab[3] = '{1'b0, 128, 32'd31};  // item 32 = r31
    atab[4] = '{1'b0, 132, 32'd0};   // DM section
    atab[5] = '{1'b1, 128, 32'd0};   // register section
    atab[6] = '{1'b1, 132, 32'd0};
    atab[7] = '{1'b1, 136, 32'd4};
    atab[8] = '{1'b1, 256, 32'd124};

    randomize_a();
    a_pc     = 32'h0000_0040;
    a_reg[5] = 32'hDEAD_BEEF;
    a_dm[0]  = 32'h1234_5678;
    for (int i = 0; i < 32; i++) b_reg[i] = $urandom;
    b_pc      = $urandom;
    b_dm_word = $urandom;

    // Reset with start held: reset must win.
    rst = 1'b1;
    a_start_drv = 1'b1;
    b_start_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_beats_start", 64'({a_if.o_busy, b_if.o_busy}), 64'd0);
    rst = 1'b0;
    a_start_drv = 1'b0;
    b_start_drv = 1'b0;
    check("reset_outputs_a",
          64'({a_if.o_busy, a_if.o_owner, a_if.o_done, a_if.o_tx_start,
               a_if.o_tx_data, a_if.o_rb_addr, a_if.o_dm_addr}), 64'd0);
    check("reset_outputs_b",
          64'({b_if.o_busy, b_if.o_owner, b_if.o_done, b_if.o_tx_start,
               b_if.o_tx_data, b_if.o_rb_addr, b_if.o_dm_addr}), 64'd0);

    // D1: full dump with latency table prologue.
    a_clear();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_start_drv = ltab[i].start;
      a_spur_drv  = ltab[i].spur;
      check($sformatf("latency_c%0d_busy_owner_txstart", i - 1),
            64'({a_if.o_busy, a_if.o_owner, a_if.o_tx_start}),
            64'(ltab[i].exp_bot));
    end
    a_start_drv = 1'b0;
    a_spur_drv  = 1'b0;
    a_finish("d1");
    for (int i = 0; i < 12; i++) begin
      check($sformatf("d1_byte%0d", btab[i].idx),
            (btab[i].idx < a_bytes.size()) ? 64'(a_bytes[btab[i].idx])
                                            : 64'hFFFF,
            64'(btab[i].val));
    end
    for (int i = 0; i < 9; i++) begin
      check($sformatf("d1_%s_at_byte%0d", atab[i].is_dm ? "dm_addr" : "rb_addr",
                      atab[i].idx),
            atab[i].is_dm ? wat(a_dmq, atab[i].idx) : wat(a_rbq, atab[i].idx),
            64'(atab[i].val));
    end

    // D2: i_start during WAIT_TX and DONE, spurious tx_done in SEND.
    a_clear();
    a_dist = 1'b1;
    @(negedge clk); a_start_drv = 1'b1;
    @(negedge clk); a_start_drv = 1'b0;
    a_finish("d2");
    a_dist = 1'b0;

    // D3: reset after byte 50, late tx_done, then a complete fresh dump.
    a_clear();
    @(negedge clk); a_start_drv = 1'b1;
    @(negedge clk); a_start_drv = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (a_bytes.size() > 50) break;
    end
    check("d3_reached_byte50", 64'(a_bytes.size() > 50), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("d3_outputs_after_rst",
          64'({a_if.o_busy, a_if.o_owner, a_if.o_done, a_if.o_tx_start,
               a_if.o_tx_data, a_if.o_rb_addr, a_if.o_dm_addr}), 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_cd == 0) break;
    end
    repeat (4) @(negedge clk);
    check("d3_late_txdone_ignored",
          64'({a_if.o_busy, a_if.o_tx_start}), 64'd0);
    check("d3_no_bytes_after_rst", 64'(a_bytes.size()), 64'd51);
    a_clear();
    @(negedge clk); a_start_drv = 1'b1;
    @(negedge clk); a_start_drv = 1'b0;
    a_finish("d3");

    // D4..D6: random contents and random UART latency.
    a_lat_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      randomize_a();
      a_clear();
      @(negedge clk); a_start_drv = 1'b1;
      @(negedge clk); a_start_drv = 1'b0;
      a_finish($sformatf("rand%0d", r));
    end
    a_lat_rand = 1'b0;

    // Small configuration: two back-to-back dumps.
    b_bytes.delete(); b_rbq.delete(); b_dmq.delete();
    @(negedge clk); b_start_drv = 1'b1;
    @(negedge clk); b_start_drv = 1'b0;
    b_wait_done("b1");
    cmp_stream("b1", b_bytes, words_to_bytes(b_words()));
    check("b1_dm_addr_last_item", wat(b_dmq, 12), 64'h100);
    check("b1_dm_addr_byte15", wat(b_dmq, 15), 64'h100);
    check("b1_rb_addr_r0", wat(b_rbq, 4), 64'd0);
    check("b1_rb_addr_r1", wat(b_rbq, 8), 64'd1);
    check("b1_dm_addr_pc_item", wat(b_dmq, 0), 64'd0);
    b_bytes.delete(); b_rbq.delete(); b_dmq.delete();
    @(negedge clk); b_start_drv = 1'b1;
    @(negedge clk); b_start_drv = 1'b0;
    check("b2_busy_after_back_to_back_start", 64'(b_if.o_busy), 64'd1);
    b_wait_done("b2");
    cmp_stream("b2", b_bytes, words_to_bytes(b_words()));
    repeat (3) @(negedge clk);
    check("b2_idle_after", 64'(b_if.o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
